eth_rx_frame_buffer: RTL and testbench
======================================

Name: eth_rx_frame_buffer

Overview:
Store-and-forward receive frame buffer between the eth_top RX AXI-Stream output (after the 8→64 upsizer) and the iDMA stream write port. It commits only complete, error-free frames to its output; bad or overflowing frames are discarded in full. The input is never back-pressured, because the MAC side cannot stall.

Parameters:
- axi_stream_req_t, eth_idma_pkg::axi_stream_req_t, AXI-Stream request struct (in and out)
- axi_stream_rsp_t, eth_idma_pkg::axi_stream_rsp_t, AXI-Stream response struct
- DataWidth, 64, tdata width in bits; multiple of 8
- Depth, 256, buffer depth in words; power of 2, ≥4
- CntWidth, 32, width of the statistics counters

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- in_req_i  in  struct  RX stream from eth_top; tuser[0]=1 on the tlast beat flags a bad frame (CRC/PHY error)
- in_rsp_o  out  struct  tready
- out_req_o  out  struct  committed frame stream to iDMA
- out_rsp_i  in  struct  tready from iDMA
- frame_cnt_o  out  CntWidth  frames committed
- drop_cnt_o  out  CntWidth  frames discarded
- fill_o  out  $clog2(Depth)+1  words currently stored (committed + speculative)

Behaviour:
- Storage and pointers
  - Storage holds {tdata, tkeep, tlast} per word.
  - Pointers are log2(Depth)+1 bits with a wrap bit: wr_ptr (speculative), commit_ptr, rd_ptr.
  - full = (wr_ptr − rd_ptr == Depth); empty_out = (rd_ptr == commit_ptr).
- Input side
  - in tready is held 1 whenever rst_ni=1; 0 during reset.
  - Input FSM states: IDLE, WRITE, DROP.
  - IDLE/WRITE, valid beat, not full: store the word, wr_ptr+1, go to WRITE.
    - If tlast and tuser[0]=0: commit_ptr ← wr_ptr+1 in the same edge, frame_cnt+1, go to IDLE.
    - If tlast and tuser[0]=1: wr_ptr ← commit_ptr (rollback), drop_cnt+1, go to IDLE.
  - Valid beat while full:
    - Not tlast: rollback, go to DROP.
    - tlast: rollback, drop_cnt+1, stay in IDLE.
  - DROP: discard beats; on tlast, drop_cnt+1 and go to IDLE. The wr_ptr is already rolled back.
  - A frame longer than Depth words is always dropped. Frames committed earlier are never affected.
- Output side
  - out tvalid = !empty_out; tdata/tkeep/tlast come from mem[rd_ptr]; tstrb = tkeep; tid/tdest/tuser = 0.
  - Combinational (fall-through) read. rd_ptr+1 on tvalid&&tready.
- Latency
  - A frame's first word becomes visible the cycle after its tlast edge.
  - Minimum latency from tlast in to first word out is 1 cycle.
- Simultaneous events
  - Read and write/commit/rollback in one cycle are independent. full uses the pre-edge rd_ptr, so it is conservative by one slot.
  - A commit while the output is empty asserts tvalid on the next cycle.
  - Rollback never moves wr_ptr below commit_ptr.
- Counters wrap modulo 2^CntWidth. fill_o = wr_ptr − rd_ptr.
- Reset, including mid-frame or mid-output: all pointers 0, FSM IDLE, counters 0, out tvalid 0, fill_o 0. Partial frames are lost and not counted.

Optional Feature:
- Macro: ETH_RX_FRAME_BUFFER_RUNT_DROP_EN.
- Defined:
  - A byte counter accumulates popcount(tkeep) per accepted beat; it saturates at 64 and is cleared on tlast, rollback and reset.
  - On tlast, a frame totalling <60 bytes (a runt, FCS already stripped) is treated as bad: rollback and drop_cnt+1.
- Undefined: no byte counter; only tuser[0] and overflow cause drops.

Decomposition:
- eth_idma_pkg gains:
  - localparam RxBufDepth = 256
  - localparam MinFrameBytes = 60
  - the typedef rxbuf_word_t {tdata, tkeep, tlast}
- Single sub-module: eth_rx_frame_buffer_mem, a simple dual-port Depth×rxbuf_word_t array with a synchronous write port and an asynchronous read port. It is a thin wrapper, so it can be swapped for a technology macro.
- Pointer and FSM logic live in the top.

Test Plan:
- Good frame: 8 beats of 64 bytes (all tkeep=0xFF), tuser=0, out tready=1 → 8 identical beats out, starting 1 cycle after the in tlast; frame_cnt=1, drop_cnt=0, fill_o returns to 0.
- Bad frame: 8 beats, tuser[0]=1 on tlast, then a good 2-beat frame → only the 2-beat frame appears; drop_cnt=1, frame_cnt=1.
- Overflow (Depth=16): a 20-beat frame, then a 4-beat frame, out tready=0 → fill_o peaks at 16 and returns to 0 after drop; drop_cnt=1. After out tready=1, only the 4-beat frame is output.
- Back-to-back: 3 frames of 3, 5 and 1 beats, no idle gap; out tready toggles 1/0 every cycle → all 9 beats in order, with tlast on beats 3, 8 and 9; frame_cnt=3.
- Reset mid-frame: assert rst_ni=0 after beat 4 of 8 while a committed frame is being read → out tvalid=0 and counters=0 immediately. After release, a new 2-beat frame passes unchanged.
- With ETH_RX_FRAME_BUFFER_RUNT_DROP_EN: a 7-beat frame, last tkeep=0x0F (52 bytes) → dropped, drop_cnt=1. An 8-beat, 60-byte frame (last tkeep=0x0F) → committed. Without the macro, both frames are committed.

Source files
------------

// File: rtl/eth_idma_pkg.sv
// Shared AXI-Stream types and RX frame buffer constants.
// The frame buffer word and input FSM states live here too.
package eth_idma_pkg;

  localparam int unsigned AxisDataW = 64;
  localparam int unsigned AxisKeepW = AxisDataW / 8;
  localparam int unsigned AxisIdW = 4;
  localparam int unsigned AxisUserW = 4;

  localparam int unsigned RxBufDepth = 256;
  localparam int unsigned MinFrameBytes = 60;

  typedef struct packed {
    logic [AxisDataW-1:0] tdata;
    logic [AxisKeepW-1:0] tstrb;
    logic [AxisKeepW-1:0] tkeep;
    logic                 tlast;
    logic [AxisIdW-1:0]   tid;
    logic [AxisIdW-1:0]   tdest;
    logic [AxisUserW-1:0] tuser;
    logic                 tvalid;
  } axi_stream_req_t;

  typedef struct packed {
    logic tready;
  } axi_stream_rsp_t;

  typedef struct packed {
    logic [AxisDataW-1:0] tdata;
    logic [AxisKeepW-1:0] tkeep;
    logic                 tlast;
  } rxbuf_word_t;

  typedef enum logic [1:0] {
    RxIdle,
    RxWrite,
    RxDrop
  } rxbuf_state_e;

endpackage

// File: rtl/eth_rx_frame_buffer_mem.sv
// Simple dual-port buffer storage: synchronous write, asynchronous read.
// Kept as a thin wrapper so it can be replaced by a technology macro.
module eth_rx_frame_buffer_mem
  import eth_idma_pkg::*;
#(
  parameter int unsigned Depth = RxBufDepth,
  parameter type word_t = rxbuf_word_t,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  word_t            wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output word_t            rdata_o
);

  word_t mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: only complete good frames reach out_req_o.
// Define ETH_RX_FRAME_BUFFER_RUNT_DROP_EN to also drop frames under 60 bytes.
module eth_rx_frame_buffer
  import eth_idma_pkg::*;
#(
  parameter type axi_stream_req_t = eth_idma_pkg::axi_stream_req_t,
  parameter type axi_stream_rsp_t = eth_idma_pkg::axi_stream_rsp_t,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth = RxBufDepth,
  parameter int unsigned CntWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  axi_stream_req_t          in_req_i,
  output axi_stream_rsp_t          in_rsp_o,
  output axi_stream_req_t          out_req_o,
  input  axi_stream_rsp_t          out_rsp_i,
  output logic [CntWidth-1:0]      frame_cnt_o,
  output logic [CntWidth-1:0]      drop_cnt_o,
  output logic [$clog2(Depth):0]   fill_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned KeepW = DataWidth / 8;

  typedef logic [AddrW:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  localparam ptr_t DepthPtr = ptr_t'(Depth);
  localparam ptr_t PtrOne = {{AddrW{1'b0}}, 1'b1};
  localparam cnt_t CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  rxbuf_state_e state_q, state_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t commit_ptr_q, commit_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t frame_cnt_q, frame_cnt_d;
  cnt_t drop_cnt_q, drop_cnt_d;

  logic full, empty_out, in_beat, out_pop;
  logic bad_frame, mem_we, unused_in;
  logic [DataWidth-1:0] in_data;
  logic [KeepW-1:0] in_keep;
  rxbuf_word_t wr_word, rd_word;

  assign in_data = in_req_i.tdata;
  assign in_keep = in_req_i.tkeep;
  assign wr_word = '{tdata: in_data, tkeep: in_keep,
                     tlast: in_req_i.tlast};

  assign in_beat = in_req_i.tvalid;
  assign full = (wr_ptr_q - rd_ptr_q) == DepthPtr;
  assign empty_out = (rd_ptr_q == commit_ptr_q);
  assign out_pop = !empty_out && out_rsp_i.tready;
  assign fill_o = wr_ptr_q - rd_ptr_q;
  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

  assign unused_in = ^{in_req_i.tstrb, in_req_i.tid,
                       in_req_i.tdest, in_req_i.tuser[AxisUserW-1:1]};

`ifdef ETH_RX_FRAME_BUFFER_RUNT_DROP_EN
  // 7 bits hold the running total even one beat past the 64 saturation.
  logic [6:0] byte_cnt_q, byte_cnt_d, byte_sum;

  always_comb begin
    byte_sum = byte_cnt_q;
    for (int i = 0; i < KeepW; i++) begin
      byte_sum += {6'd0, in_keep[i]};
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (in_beat) begin
      if (state_q == RxDrop || full || in_req_i.tlast) begin
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = (byte_sum > 7'd64) ? 7'd64 : byte_sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign bad_frame = in_req_i.tuser[0] ||
                     (byte_sum < 7'(MinFrameBytes));
`else
  assign bad_frame = in_req_i.tuser[0];
`endif

  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d = out_pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d = drop_cnt_q;
    mem_we = 1'b0;
    if (in_beat) begin
      unique case (1'b1)
        (state_q == RxDrop): begin
          if (in_req_i.tlast) begin
            drop_cnt_d = drop_cnt_q + CntOne;
            state_d = RxIdle;
          end
        end
        (state_q != RxDrop) && full: begin
          wr_ptr_d = commit_ptr_q;
          if (in_req_i.tlast) begin
            drop_cnt_d = drop_cnt_q + CntOne;
            state_d = RxIdle;
          end else begin
            state_d = RxDrop;
          end
        end
        default: begin
          mem_we = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          state_d = RxWrite;
          if (in_req_i.tlast) begin
            state_d = RxIdle;
            if (bad_frame) begin
              wr_ptr_d = commit_ptr_q;
              drop_cnt_d = drop_cnt_q + CntOne;
            end else begin
              commit_ptr_d = wr_ptr_q + PtrOne;
              frame_cnt_d = frame_cnt_q + CntOne;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RxIdle;
      wr_ptr_q <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  eth_rx_frame_buffer_mem #(
    .Depth  (Depth),
    .word_t (rxbuf_word_t)
  ) i_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AddrW-1:0]),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q[AddrW-1:0]),
    .rdata_o (rd_word)
  );

  always_comb begin
    in_rsp_o = '0;
    in_rsp_o.tready = rst_ni;
  end

  always_comb begin
    out_req_o = '0;
    out_req_o.tvalid = !empty_out;
    out_req_o.tdata = rd_word.tdata;
    out_req_o.tkeep = rd_word.tkeep;
    out_req_o.tstrb = rd_word.tkeep;
    out_req_o.tlast = rd_word.tlast;
  end

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Scoreboard bench for eth_rx_frame_buffer (Depth=16).
// Expected words are queued at stimulus time and popped by the output monitor.
module tb_eth_rx_frame_buffer;
  import eth_idma_pkg::*;

  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_stream_req_t in_req, out_req;
  axi_stream_rsp_t in_rsp, out_rsp;
  logic [31:0] frame_cnt, drop_cnt;
  logic [4:0] fill;

  eth_rx_frame_buffer #(
    .Depth (Depth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_req_i    (in_req),
    .in_rsp_o    (in_rsp),
    .out_req_o   (out_req),
    .out_rsp_i   (out_rsp),
    .frame_cnt_o (frame_cnt),
    .drop_cnt_o  (drop_cnt),
    .fill_o      (fill)
  );

  rxbuf_word_t exp_q[$];
  rxbuf_word_t mon_w;
  int n_checks = 0;
  int n_errors = 0;
  int exp_frames = 0;
  int exp_drops = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_data(int tag, int i);
    return {8'(tag), 24'hC0FFEE, 24'(i * 3 + 1), 8'(i)};
  endfunction

  function automatic int popc(logic [7:0] k);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(k[i]);
    return c;
  endfunction

  task automatic set_beat(logic [63:0] d, logic [7:0] k, logic last, logic bad);
    in_req = '0;
    in_req.tvalid = 1'b1;
    in_req.tdata = d;
    in_req.tkeep = k;
    in_req.tstrb = k;
    in_req.tlast = last;
    in_req.tuser = {3'b000, bad};
  endtask

  task automatic beat(logic [63:0] d, logic [7:0] k, logic last, logic bad);
    set_beat(d, k, last, bad);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(int n);
    in_req = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(int tag, int n, logic [7:0] last_keep);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{tdata: mk_data(tag, i),
                        tkeep: (i == n - 1) ? last_keep : 8'hFF,
                        tlast: (i == n - 1)});
    end
    exp_frames++;
  endtask

  task automatic send_frame(int tag, int n, logic [7:0] last_keep, logic bad);
    int bytes;
    logic ok;
    bytes = (n - 1) * 8 + popc(last_keep);
    ok = !bad;
`ifdef ETH_RX_FRAME_BUFFER_RUNT_DROP_EN
    if (bytes < MinFrameBytes) ok = 1'b0;
`endif
    if (ok) push_frame(tag, n, last_keep);
    else exp_drops++;
    for (int i = 0; i < n; i++) begin
      beat(mk_data(tag, i), (i == n - 1) ? last_keep : 8'hFF, i == n - 1, bad);
    end
  endtask

  task automatic check_counters();
    chk("frame_cnt", frame_cnt, 64'(exp_frames));
    chk("drop_cnt", drop_cnt, 64'(exp_drops));
  endtask

  task automatic do_reset();
    in_req = '0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    @(posedge clk);
    #1;
    chk("reset_tready", in_rsp.tready, 0);
    chk("reset_tvalid", out_req.tvalid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_tready", in_rsp.tready, 1);
    chk("post_reset_fill", fill, 0);
    check_counters();
  endtask

  task automatic wait_drain(int budget);
    int k = 0;
    while ((exp_q.size() != 0 || out_req.tvalid) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_fill", fill, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_req.tvalid && out_rsp.tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", out_req.tdata, 64'hDEAD);
      end else begin
        mon_w = exp_q.pop_front();
        chk("out_tdata", out_req.tdata, mon_w.tdata);
        chk("out_tkeep_tlast", {out_req.tkeep, out_req.tlast},
            {mon_w.tkeep, mon_w.tlast});
        chk("out_tstrb", out_req.tstrb, mon_w.tkeep);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    in_req = '0;
    out_rsp = '0;
    do_reset();

    // good frame with latency check on the tlast edge
    out_rsp.tready = 1'b1;
    push_frame(1, 8, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      set_beat(mk_data(1, i), 8'hFF, i == 7, 1'b0);
      if (i == 7) begin
        @(negedge clk);
        chk("lat_pre_tvalid", out_req.tvalid, 0);
      end
      @(posedge clk);
      #1;
      if (i == 7) chk("lat_post_tvalid", out_req.tvalid, 1);
    end
    go_idle(1);
    wait_drain(100);
    check_counters();
    chk("good_frame_cnt", frame_cnt, 1);

    // bad frame then good 2-beat frame
    do_reset();
    out_rsp.tready = 1'b1;
    send_frame(2, 8, 8'hFF, 1'b1);
    send_frame(3, 2, 8'hFF, 1'b0);
    go_idle(1);
    wait_drain(100);
    check_counters();

    // overflow with stalled output
    do_reset();
    out_rsp.tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat(mk_data(4, i), 8'hFF, i == 19, 1'b0);
      if (i == 15) chk("fill_peak", fill, 16);
      if (i == 16) chk("fill_rollback", fill, 0);
    end
    exp_drops++;
    send_frame(5, 4, 8'hFF, 1'b0);
    go_idle(1);
    chk("fill_held", fill, 64'(exp_q.size()));
    chk("held_tvalid", out_req.tvalid, 64'(exp_q.size() != 0));
    chk("ovf_drop_cnt", drop_cnt, 1);
    out_rsp.tready = 1'b1;
    wait_drain(100);
    check_counters();

    // back-to-back frames with toggling output ready
    do_reset();
    out_rsp.tready = 1'b1;
    fork
      begin
        send_frame(6, 3, 8'hFF, 1'b0);
        send_frame(7, 5, 8'hFF, 1'b0);
        send_frame(8, 1, 8'hFF, 1'b0);
        go_idle(1);
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_rsp.tready = ~out_rsp.tready;
        end
      end
    join
    out_rsp.tready = 1'b1;
    wait_drain(100);
    check_counters();

    // reset mid-frame while a committed frame is being read
    do_reset();
    out_rsp.tready = 1'b1;
    send_frame(9, 8, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) beat(mk_data(10, i), 8'hFF, 1'b0, 1'b0);
    chk("mid_read_left", exp_q.size(), 4);
    rst_n = 1'b0;
    in_req = '0;
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    #1;
    chk("async_rst_tvalid", out_req.tvalid, 0);
    chk("async_rst_fill", fill, 0);
    check_counters();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(11, 2, 8'hFF, 1'b0);
    go_idle(1);
    wait_drain(100);
    check_counters();

    // short final beats: 52-byte and 60-byte frames
    do_reset();
    out_rsp.tready = 1'b1;
    send_frame(12, 7, 8'h0F, 1'b0);
    send_frame(13, 8, 8'h0F, 1'b0);
    go_idle(1);
    wait_drain(100);
`ifdef ETH_RX_FRAME_BUFFER_RUNT_DROP_EN
    chk("runt_frames", frame_cnt, 1);
    chk("runt_drops", drop_cnt, 1);
`else
    chk("runt_frames", frame_cnt, 2);
    chk("runt_drops", drop_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
